// File: rtl/knitter_pkg.sv
// Shared types and helpers for the sock knitting controller.
package knitter_pkg;

   localparam logic [2:0] STATE_CODE_IDLE   = 3'b000;
   localparam logic [2:0] STATE_CODE_KNIT   = 3'b001;
   localparam logic [2:0] STATE_CODE_PAUSE  = 3'b010;
   localparam logic [2:0] STATE_CODE_FINISH = 3'b011;

   typedef enum logic [2:0] {
      StIdle   = STATE_CODE_IDLE,
      StKnit   = STATE_CODE_KNIT,
      StPause  = STATE_CODE_PAUSE,
      StFinish = STATE_CODE_FINISH
   } knit_state_e;

   function automatic int unsigned target_rows(input int unsigned size,
                                               input int unsigned base,
                                               input int unsigned step);
      return base + size * step;
   endfunction

endpackage

// File: rtl/knit_row_ctr.sv
// Loadable, clearable up-counter with a terminal-match flag.
// Clear has priority over load, load over increment; otherwise the count holds.
module knit_row_ctr #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic [W-1:0] match_val,
   output logic [W-1:0] cnt,
   output logic         match
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign match = (cnt == match_val);

endmodule

// File: rtl/knitter_ctrl.sv
// Knitting-machine controller: knits batches of socks sized by size_sel.
// Optional PAUSE timeout with sticky fault flag: define KNITTER_YARN_TIMEOUT_EN.
module knitter_ctrl
   import knitter_pkg::*;
#(
   parameter int unsigned NUM_SIZES   = 4,
   parameter int unsigned SIZE_W      = 2,
   parameter int unsigned ROW_W       = 8,
   parameter int unsigned ROWS_BASE   = 6,
   parameter int unsigned ROWS_STEP   = 2,
   parameter int unsigned BATCH_W     = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SIZE_W-1:0]  size_sel,
   input  logic [BATCH_W-1:0] batch_len,
   input  logic               start,
   input  logic               stop,
   input  logic               yarn_ok,
   output logic               knit_en,
   output logic               busy,
   output logic [ROW_W-1:0]   row_cnt,
   output logic               sock_done,
   output logic               batch_done,
   output logic               size_err,
   output logic               fault,
   output logic [CNT_W-1:0]   socks_made,
   output logic [2:0]         state_code
);

   knit_state_e        state_q, state_d;
   logic [ROW_W-1:0]   target_q;
   logic [BATCH_W-1:0] batch_tgt_q, batch_cnt_q;
   logic [CNT_W-1:0]   socks_q;
   logic               knit_en_q, busy_q, sock_done_q, batch_done_q, size_err_q;

   logic               size_ok, accept, size_rej, finish_entry, last_sock;
   logic               row_clr, row_inc, row_match, tmo_hit, tmo_fire;
   logic [ROW_W-1:0]   target_new;
   logic [BATCH_W:0]   batch_eff;

   assign size_ok    = 32'(size_sel) < NUM_SIZES;
   assign target_new = ROW_W'(target_rows(32'(size_sel), ROWS_BASE, ROWS_STEP));
   // A batch length of zero is treated as a single sock.
   assign batch_eff  = (batch_tgt_q == '0) ? (BATCH_W+1)'(1) : {1'b0, batch_tgt_q};
   assign last_sock  = ({1'b0, batch_cnt_q} + 1'b1) == batch_eff;

   knit_row_ctr #(.W(ROW_W)) u_row_ctr (
      .clk       (clk),
      .reset     (reset),
      .clr       (row_clr),
      .load      (1'b0),
      .load_val  ('0),
      .inc       (row_inc),
      .match_val (target_q - 1'b1),
      .cnt       (row_cnt),
      .match     (row_match)
   );

   always_comb begin
      state_d      = state_q;
      row_clr      = 1'b0;
      row_inc      = 1'b0;
      accept       = 1'b0;
      size_rej     = 1'b0;
      finish_entry = 1'b0;
      tmo_fire     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && !stop) begin
               if (!size_ok) begin
                  size_rej = 1'b1;
               end else if (yarn_ok) begin
                  accept  = 1'b1;
                  row_clr = 1'b1;
                  state_d = StKnit;
               end
            end
         end
         StKnit: begin
            if (stop) begin
               row_clr = 1'b1;
               state_d = StIdle;
            end else begin
               // The row in progress completes even when yarn drops this cycle.
               row_inc = 1'b1;
               if (row_match) begin
                  finish_entry = 1'b1;
                  state_d      = StFinish;
               end else if (!yarn_ok) begin
                  state_d = StPause;
               end
            end
         end
         StPause: begin
            if (stop) begin
               row_clr = 1'b1;
               state_d = StIdle;
            end else if (start && yarn_ok) begin
               state_d = StKnit;
            end else if (tmo_hit) begin
               row_clr  = 1'b1;
               tmo_fire = 1'b1;
               state_d  = StIdle;
            end
         end
         StFinish: begin
            row_clr = 1'b1;
            if (batch_done_q || stop) begin
               state_d = StIdle;
            end else if (yarn_ok) begin
               state_d = StKnit;
            end else begin
               state_d = StPause;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         target_q     <= '0;
         batch_tgt_q  <= '0;
         batch_cnt_q  <= '0;
         socks_q      <= '0;
         knit_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         sock_done_q  <= 1'b0;
         batch_done_q <= 1'b0;
         size_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         knit_en_q    <= (state_d == StKnit);
         busy_q       <= (state_d != StIdle);
         sock_done_q  <= finish_entry;
         batch_done_q <= finish_entry && last_sock;
         size_err_q   <= size_rej;
         if (accept) begin
            target_q    <= target_new;
            batch_tgt_q <= batch_len;
            batch_cnt_q <= '0;
         end else if (finish_entry) begin
            batch_cnt_q <= batch_cnt_q + 1'b1;
         end
         if (finish_entry) begin
            socks_q <= socks_q + 1'b1;
         end
      end
   end

`ifdef KNITTER_YARN_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             fault_q;

   // Restarts on every entry to PAUSE so only consecutive PAUSE cycles count.
   knit_row_ctr #(.W(TMO_W)) u_tmo_ctr (
      .clk       (clk),
      .reset     (reset),
      .clr       ((state_d == StPause) && (state_q != StPause)),
      .load      (1'b0),
      .load_val  ('0),
      .inc       (state_q == StPause),
      .match_val (TMO_W'(TIMEOUT_CYC - 1)),
      .cnt       (tmo_cnt),
      .match     (tmo_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault_q <= 1'b0;
      end else if (accept) begin
         fault_q <= 1'b0;
      end else if (tmo_fire) begin
         fault_q <= 1'b1;
      end
   end

   assign fault = fault_q;
`else
   logic unused_tmo_cfg;

   assign tmo_hit        = 1'b0;
   assign fault          = 1'b0;
   assign unused_tmo_cfg = ^{TIMEOUT_CYC, tmo_fire};
`endif

   assign knit_en    = knit_en_q;
   assign busy       = busy_q;
   assign sock_done  = sock_done_q;
   assign batch_done = batch_done_q;
   assign size_err   = size_err_q;
   assign socks_made = socks_q;
   assign state_code = state_q;

endmodule

// File: tb/tb_knitter_ctrl.sv
// Directed self-checking bench for knitter_ctrl (SIZE_W widened to 3 so size 4 is drivable).
module tb_knitter_ctrl;

   localparam int unsigned TMO = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  size_sel = '0;
   logic [3:0]  batch_len = '0;
   logic        start = 1'b0, stop = 1'b0, yarn_ok = 1'b0;
   logic        knit_en, busy, sock_done, batch_done, size_err, fault;
   logic [7:0]  row_cnt;
   logic [15:0] socks_made;
   logic [2:0]  state_code;

   int checks = 0;
   int errors = 0;

   knitter_ctrl #(
      .NUM_SIZES (4), .SIZE_W (3), .ROW_W (8), .ROWS_BASE (6), .ROWS_STEP (2),
      .BATCH_W (4), .CNT_W (16), .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .size_sel   (size_sel),
      .batch_len  (batch_len),
      .start      (start),
      .stop       (stop),
      .yarn_ok    (yarn_ok),
      .knit_en    (knit_en),
      .busy       (busy),
      .row_cnt    (row_cnt),
      .sock_done  (sock_done),
      .batch_done (batch_done),
      .size_err   (size_err),
      .fault      (fault),
      .socks_made (socks_made),
      .state_code (state_code)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"}, {knit_en, busy, sock_done, batch_done, size_err, fault}, 0);
      check_eq({tag, "_row"}, row_cnt, 0);
      check_eq({tag, "_socks"}, socks_made, 0);
      check_eq({tag, "_state"}, state_code, 0);
   endtask

   // Issue a one-cycle start; returns just after the accepting edge (first KNIT cycle).
   task automatic launch(input logic [2:0] sz, input logic [3:0] bl);
      size_sel  = sz;
      batch_len = bl;
      yarn_ok   = 1'b1;
      start     = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int sd_n, bd_n, bd_cyc;
      int sd_cyc[3];

      #2 reset = 1'b0;
      #1 check_all_zero("reset");
      step();
      step();
      reset = 1'b1;

      // Size 1, one sock: 8 KNIT cycles, FINISH on cycle 9, IDLE on cycle 10
      launch(3'd1, 4'd1);
      for (int i = 0; i < 8; i++) begin
         check_eq("t1_knit_en", knit_en, 1);
         check_eq("t1_row", row_cnt, i);
         check_eq("t1_no_done", sock_done, 0);
         step();
      end
      check_eq("t1_finish", state_code, 3);
      check_eq("t1_sock_done", sock_done, 1);
      check_eq("t1_batch_done", batch_done, 1);
      check_eq("t1_socks", socks_made, 1);
      check_eq("t1_knit_off", knit_en, 0);
      step();
      check_eq("t1_busy_low", busy, 0);
      check_eq("t1_idle", state_code, 0);
      check_eq("t1_pulse_end", sock_done, 0);

      // Size 0, batch of 3: FINISH every 7 cycles, batch_done only on the third
      sd_n = 0; bd_n = 0; bd_cyc = 0;
      sd_cyc = '{0, 0, 0};
      launch(3'd0, 4'd3);
      for (int c = 1; c <= 25; c++) begin
         if (sock_done) begin
            if (sd_n < 3) sd_cyc[sd_n] = c;
            sd_n++;
         end
         if (batch_done) begin
            bd_n++;
            bd_cyc = c;
         end
         step();
      end
      check_eq("t2_sock_n", sd_n, 3);
      check_eq("t2_sock0", sd_cyc[0], 7);
      check_eq("t2_sock1", sd_cyc[1], 14);
      check_eq("t2_sock2", sd_cyc[2], 21);
      check_eq("t2_batch_n", bd_n, 1);
      check_eq("t2_batch_cyc", bd_cyc, 21);
      check_eq("t2_socks", socks_made, 4);
      check_eq("t2_idle", state_code, 0);

      // Yarn loss at row 4: the detect-cycle row counts, then hold at 5
      launch(3'd1, 4'd1);
      repeat (4) step();
      check_eq("t3_row4", row_cnt, 4);
      yarn_ok = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         check_eq("t3_pause", state_code, 2);
         check_eq("t3_hold", row_cnt, 5);
         check_eq("t3_knit_off", knit_en, 0);
         step();
      end
      yarn_ok = 1'b1;
      step();
      check_eq("t3_wait_start", state_code, 2);
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("t3_resume", knit_en, 1);
      check_eq("t3_resume_row", row_cnt, 5);
      step();
      step();
      check_eq("t3_last_row", row_cnt, 7);
      check_eq("t3_not_done", sock_done, 0);
      step();
      check_eq("t3_done", sock_done, 1);
      check_eq("t3_socks", socks_made, 5);
      step();

      // Stop together with start at row 5 discards the sock
      launch(3'd3, 4'd2);
      repeat (5) step();
      check_eq("t4_row5", row_cnt, 5);
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      check_eq("t4_idle", state_code, 0);
      check_eq("t4_row_clr", row_cnt, 0);
      check_eq("t4_no_done", sock_done, 0);
      check_eq("t4_busy", busy, 0);
      check_eq("t4_socks", socks_made, 5);

      // Illegal size rejected; yarn-less start ignored
      size_sel = 3'd4;
      start    = 1'b1;
      step();
      start = 1'b0;
      check_eq("t5_size_err", size_err, 1);
      check_eq("t5_stay_idle", state_code, 0);
      step();
      check_eq("t5_err_pulse", size_err, 0);
      size_sel = 3'd0;
      yarn_ok  = 1'b0;
      start    = 1'b1;
      step();
      start = 1'b0;
      check_eq("t5_no_yarn", state_code, 0);
      check_eq("t5_no_err", size_err, 0);

      // Yarn drop on the last row still finishes; stop during FINISH ends the batch
      launch(3'd0, 4'd2);
      repeat (5) step();
      check_eq("t6_row5", row_cnt, 5);
      yarn_ok = 1'b0;
      step();
      check_eq("t6_finish", state_code, 3);
      check_eq("t6_sock_done", sock_done, 1);
      check_eq("t6_not_last", batch_done, 0);
      check_eq("t6_socks", socks_made, 6);
      yarn_ok = 1'b1;
      stop    = 1'b1;
      step();
      stop = 1'b0;
      check_eq("t6_idle", state_code, 0);
      check_eq("t6_socks_kept", socks_made, 6);

`ifdef KNITTER_YARN_TIMEOUT_EN
      launch(3'd0, 4'd1);
      step();
      yarn_ok = 1'b0;
      step();
      for (int i = 0; i < int'(TMO); i++) begin
         check_eq("t7_pause", state_code, 2);
         check_eq("t7_no_fault", fault, 0);
         step();
      end
      check_eq("t7_idle", state_code, 0);
      check_eq("t7_fault", fault, 1);
      check_eq("t7_row_clr", row_cnt, 0);
      launch(3'd0, 4'd1);
      check_eq("t7_fault_clr", fault, 0);
      repeat (8) step();
`endif

      // Asynchronous reset in the middle of a sock
      launch(3'd0, 4'd1);
      repeat (3) step();
      check_eq("t8_row3", row_cnt, 3);
      #2 reset = 1'b0;
      #1 check_all_zero("t8_async");
      step();
      reset = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/knitter_ctrl.md
Name: knitter_ctrl

Overview:
Parametrised knitting-machine controller for the sock factory line. Knits batches of socks in a selectable size. Row count per sock is derived from the size. Pauses on yarn loss and resumes on operator start; stop aborts the batch. Sits between the operator panel (size select, buttons, yarn sensor) and the knitting head drive and production counters.

Parameters:
NUM_SIZES, 4, number of valid sizes; size_sel values 0..NUM_SIZES-1 are legal.
SIZE_W, 2, width of size_sel.
ROW_W, 8, width of row counter.
ROWS_BASE, 6, rows for size 0.
ROWS_STEP, 2, extra rows per size step; target = ROWS_BASE + size*ROWS_STEP (must fit ROW_W).
BATCH_W, 4, width of batch_len.
CNT_W, 16, width of lifetime sock counter.
TIMEOUT_CYC, 100, PAUSE timeout, used only with the optional feature.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
size_sel  in  SIZE_W  requested size, sampled on accepted start.
batch_len  in  BATCH_W  socks per batch, sampled on accepted start; 0 treated as 1.
start  in  1  level, operator start/resume.
stop  in  1  level, abort; priority over start.
yarn_ok  in  1  yarn sensor, 1 = yarn present.
knit_en  out  1  drive enable to knitting head.
busy  out  1  1 in any state except IDLE.
row_cnt  out  ROW_W  rows done on current sock.
sock_done  out  1  one-cycle pulse per completed sock.
batch_done  out  1  one-cycle pulse on last sock of batch.
size_err  out  1  one-cycle pulse when start is rejected for illegal size.
fault  out  1  sticky yarn-timeout flag; tied 0 without the optional feature.
socks_made  out  CNT_W  lifetime completed socks; wraps; cleared only by reset.
state_code  out  3  IDLE=000, KNIT=001, PAUSE=010, FINISH=011.

Behaviour:
- Reset (reset=0, async):
  - state IDLE; all outputs 0.
  - Latched size, latched batch target and batch counter all 0.
- All outputs are registered.
- IDLE:
  - start=1, stop=0, yarn_ok=1, size_sel<NUM_SIZES -> KNIT next cycle.
  - On that transition: latch target and batch_len; row_cnt=0; batch counter=0.
  - start with size_sel>=NUM_SIZES -> size_err pulse next cycle; stay IDLE.
  - start with yarn_ok=0 -> ignored.
- KNIT:
  - knit_en=1; row_cnt increments by 1 each cycle.
  - When row_cnt==target-1 -> FINISH.
  - yarn_ok=0 -> PAUSE; row_cnt holds; knit_en=0 next cycle. The increment on the detect cycle still occurs.
- PAUSE:
  - knit_en=0; row_cnt holds.
  - start=1 and yarn_ok=1 -> KNIT. Resumes from the held row_cnt.
- FINISH (one cycle):
  - sock_done=1; socks_made+1; batch counter+1.
  - If this is the last sock of the batch: batch_done=1 -> IDLE.
  - Otherwise: row_cnt=0 -> KNIT if yarn_ok=1, else PAUSE.
- stop=1 in KNIT or PAUSE:
  - -> IDLE next cycle; row_cnt cleared.
  - No sock_done and no count change; the partial sock is discarded.
- stop in FINISH is ignored: the completing sock counts. The controller then goes to IDLE instead of continuing the batch.
- Simultaneous start and stop: stop wins.
- Simultaneous yarn_ok drop on the last row: FINISH is still taken.
- Latency example: start accepted at edge 0 with target 8 -> KNIT cycles 1-8, FINISH cycle 9, IDLE cycle 10.

Optional Feature:
KNITTER_YARN_TIMEOUT_EN.
- Defined: a counter runs in PAUSE, cleared on entry.
  - After TIMEOUT_CYC consecutive PAUSE cycles -> IDLE, fault=1, row_cnt cleared.
  - fault is cleared only by the next accepted start or by reset.
- Undefined: PAUSE waits indefinitely; fault is constant 0; no timeout counter is synthesised.

Decomposition:
- Package knitter_pkg holds:
  - state enum and the 3-bit state_code constants;
  - target-rows function (ROWS_BASE + size*ROWS_STEP).
- One sub-module, knit_row_ctr.
  - Loadable, clearable, hold-able up-counter with a terminal-match output.
  - Instantiated for row_cnt; reused for the timeout counter when the feature is enabled.

Test Plan:
- Reset mid-KNIT (row_cnt=3) -> all outputs 0 immediately (async), state_code=000.
- size_sel=1, batch_len=1, start one cycle -> knit_en high 8 cycles (row_cnt 0..7), sock_done and batch_done on cycle 9, socks_made=1, busy low cycle 10.
- size_sel=0, batch_len=3 -> three FINISH pulses spaced 7 cycles apart, batch_done only on the third, socks_made=3.
- size_sel=1, yarn_ok low at row_cnt=4 for 10 cycles, then yarn_ok=1 + start -> row_cnt resumes from 5, sock_done after remaining 3 KNIT cycles.
- size_sel=3 at KNIT row 5, stop=1 with start=1 -> IDLE next cycle, no sock_done, socks_made unchanged; size_sel=4 with NUM_SIZES=4 -> size_err pulse, stays IDLE.
- With KNITTER_YARN_TIMEOUT_EN, TIMEOUT_CYC=20: yarn lost in KNIT -> IDLE and fault=1 after 20 PAUSE cycles; next valid start clears fault.
